// File: rtl/kayrv32_pkg.sv
// kayrv32_pkg: shared widths, constants and helpers for the kayrv32 front end.
// Holds XLEN/INSTR_W, PC_STEP, the default reset PC, the NOP encoding and the
// {pc, instr} fetch entry used between the fetch FIFO and the fetch unit.
package kayrv32_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [XLEN-1:0]    RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, instr} entries for instr_fetch.
// Ports: p_Clk/p_Rst (async, active-high), p_Push/p_Data_In, p_Pop,
// p_Flush (clears all entries at the edge), p_Head_Out (0 when empty),
// p_Occ_Out (entry count). DEPTH must be a power of two (2 or 4).
module fetch_fifo
    import kayrv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          p_Clk,
    input  logic          p_Rst,
    input  logic          p_Push,
    input  logic [W-1:0]  p_Data_In,
    input  logic          p_Pop,
    input  logic          p_Flush,
    output logic [W-1:0]  p_Head_Out,
    output logic [CW-1:0] p_Occ_Out
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] occ_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge p_Clk or posedge p_Rst) begin
        if (p_Rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else if (p_Flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (p_Push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (p_Pop) begin
                rd_q <= rd_q + 1'b1;
            end
            occ_q <= occ_q + CW'(p_Push) - CW'(p_Pop);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge p_Clk) begin
        if (p_Push && !p_Flush) begin
            mem[wr_q] <= p_Data_In;
        end
    end

    assign p_Head_Out = (occ_q != '0) ? mem[rd_q] : '0;
    assign p_Occ_Out  = occ_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, issue and in-flight tracking for the instruction fetch stage.
// Drives the 1-cycle-latency memory read port (p_MemReadEn_Out/p_MemAddr_Out,
// p_MemData_In), buffers responses in fetch_fifo and presents them to decode
// via p_InstrValid_Out/p_InstrReady_In/p_Instr_Out/p_InstrPc_Out.
// p_Redirect_In/p_RedirectPc_In flush the stage and reload the PC.
// Optional macro KAYRV32_FETCH_PERFCNT_EN adds p_StallCnt_Out, a saturating
// count of cycles out of reset with no valid instruction.
module instr_fetch
    import kayrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        p_Clk,
    input  logic        p_Rst,
    output logic        p_MemReadEn_Out,
    output logic [31:0] p_MemAddr_Out,
    input  logic [31:0] p_MemData_In,
    input  logic        p_Redirect_In,
    input  logic [31:0] p_RedirectPc_In,
    output logic        p_InstrValid_Out,
    input  logic        p_InstrReady_In,
    output logic [31:0] p_Instr_Out,
    output logic [31:0] p_InstrPc_Out
`ifdef KAYRV32_FETCH_PERFCNT_EN
    ,
    output logic [31:0] p_StallCnt_Out
`endif
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            inflight_q;

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   occ;
    logic [CW:0]     budget;
    fetch_entry_t    head;
    fetch_entry_t    rsp;

    // Entries that will be held after this edge if we do not issue:
    // buffered + the response landing now - the one decode takes now.
    always_comb begin
        budget = {1'b0, occ}
               + {{CW{1'b0}}, inflight_q}
               - {{CW{1'b0}}, pop};
    end

    assign issue = ~p_Rst & ~p_Redirect_In & (budget < DEPTH_C);
    assign push  = inflight_q & ~p_Redirect_In;

    assign p_MemReadEn_Out = issue;
    assign p_MemAddr_Out   = pc_q;

    always_ff @(posedge p_Clk or posedge p_Rst) begin
        if (p_Rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (p_Redirect_In) begin
            pc_q       <= align_pc(p_RedirectPc_In);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q     <= pc_q + XLEN'(PC_STEP);
                rsp_pc_q <= pc_q;
            end
        end
    end

    assign rsp.pc    = rsp_pc_q;
    assign rsp.instr = p_MemData_In;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .p_Clk      (p_Clk),
        .p_Rst      (p_Rst),
        .p_Push     (push),
        .p_Data_In  (rsp),
        .p_Pop      (pop),
        .p_Flush    (p_Redirect_In),
        .p_Head_Out (head),
        .p_Occ_Out  (occ)
    );

    // A redirect hides the head so nothing stale is consumed that cycle.
    assign p_InstrValid_Out = (occ != '0) & ~p_Redirect_In;
    assign pop              = p_InstrValid_Out & p_InstrReady_In;
    assign p_Instr_Out      = head.instr;
    assign p_InstrPc_Out    = head.pc;

`ifdef KAYRV32_FETCH_PERFCNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge p_Clk or posedge p_Rst) begin
        if (p_Rst) begin
            stall_q <= '0;
        end else if (!p_InstrValid_Out && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign p_StallCnt_Out = stall_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a queue scoreboard.
// A second instance starts at 32'hFFFF_FFF8 to cover PC wrap.
module tb_instr_fetch;
    import kayrv32_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_w;
    logic        redir, rdy, rdy_w;
    logic [31:0] rpc;
    logic        en, valid, en_w, valid_w;
    logic [31:0] addr, instr, ipc, mdat;
    logic [31:0] addr_w, instr_w, ipc_w, mdat_w;
`ifdef KAYRV32_FETCH_PERFCNT_EN
    logic [31:0] stall, stall_w;
`endif

    int total = 0;
    int bad   = 0;
    int wcount = 0;
    logic [63:0] q[$];
    logic [63:0] qw[$];

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .p_Clk(clk), .p_Rst(rst),
        .p_MemReadEn_Out(en), .p_MemAddr_Out(addr), .p_MemData_In(mdat),
        .p_Redirect_In(redir), .p_RedirectPc_In(rpc),
        .p_InstrValid_Out(valid), .p_InstrReady_In(rdy),
        .p_Instr_Out(instr), .p_InstrPc_Out(ipc)
`ifdef KAYRV32_FETCH_PERFCNT_EN
        , .p_StallCnt_Out(stall)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .p_Clk(clk), .p_Rst(rst_w),
        .p_MemReadEn_Out(en_w), .p_MemAddr_Out(addr_w), .p_MemData_In(mdat_w),
        .p_Redirect_In(1'b0), .p_RedirectPc_In(32'h0),
        .p_InstrValid_Out(valid_w), .p_InstrReady_In(rdy_w),
        .p_Instr_Out(instr_w), .p_InstrPc_Out(ipc_w)
`ifdef KAYRV32_FETCH_PERFCNT_EN
        , .p_StallCnt_Out(stall_w)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (en)   mdat   <= word_at(addr);
        if (en_w) mdat_w <= word_at(addr_w);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            q.push_back({p, word_at(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic push_seq_w(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            qw.push_back({p, word_at(p)});
            p = p + 32'd4;
        end
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, score accepts.
    task automatic cyc(input logic r, input logic rd, input logic [31:0] rp);
        @(negedge clk);
        rdy   = r;
        redir = rd;
        rpc   = rp;
        wcount++;
        rdy_w = (wcount < 10);
        #1;
        if (valid && rdy) begin
            chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) chk("deliver", {ipc, instr}, q.pop_front());
        end
        if (valid_w && rdy_w) begin
            chk("sbw_nonempty", 64'(qw.size() != 0), 64'd1);
            if (qw.size() != 0) chk("deliver_w", {ipc_w, instr_w}, qw.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        rdy = 1'b1; rdy_w = 1'b1;
        redir = 1'b0; rpc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_addr", 64'(addr), 64'h0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_ipc", 64'(ipc), 64'h0);
        chk("rst_addr_w", 64'(addr_w), 64'hFFFF_FFF8);
        chk("rst_en_w", 64'(en_w), 64'd0);
`ifdef KAYRV32_FETCH_PERFCNT_EN
        chk("rst_stall", 64'(stall), 64'd0);
`endif
        push_seq(32'h0, 40);
        push_seq_w(32'hFFFF_FFF8, 20);

        // c0: release
        @(negedge clk);
        rst = 1'b0; rst_w = 1'b0;
        #1;
        chk("c0_en", 64'(en), 64'd1);
        chk("c0_addr", 64'(addr), 64'h0);
        chk("c0_valid", 64'(valid), 64'd0);
        chk("c0_addr_w", 64'(addr_w), 64'hFFFF_FFF8);
        cyc(1'b1, 1'b0, 32'h0);
        chk("c1_addr", 64'(addr), 64'h4);
        chk("c1_valid", 64'(valid), 64'd0);
        chk("c1_addr_w", 64'(addr_w), 64'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0);
        chk("c2_valid", 64'(valid), 64'd1);
        chk("c2_addr", 64'(addr), 64'h8);
        chk("c2_addr_w", 64'(addr_w), 64'h0);
`ifdef KAYRV32_FETCH_PERFCNT_EN
        chk("c2_stall", 64'(stall), 64'd2);
`endif
        for (int i = 3; i < 8; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk("stream_addr", 64'(addr), 64'(32'(4 * i)));
            chk("stream_en", 64'(en), 64'd1);
        end

        // back-pressure: head must hold, fetch must stop
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("bp_en", 64'(en), 64'd0);
            chk("bp_valid", 64'(valid), 64'd1);
            chk("bp_head", {ipc, instr}, q[0]);
        end
        chk("bp_head_pc", 64'(q[0][63:32]), 64'd24);
        cyc(1'b1, 1'b0, 32'h0);
        chk("resume_addr", 64'(addr), 64'd32);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        chk("pre_redir_next", 64'(q[0][63:32]), 64'd40);

        // redirect from steady stream (entry buffered + read in flight)
        cyc(1'b1, 1'b1, 32'h0000_0102);
        chk("redir_valid", 64'(valid), 64'd0);
        chk("redir_en", 64'(en), 64'd0);
        q.delete();
        push_seq(32'h0000_0100, 30);
        cyc(1'b1, 1'b0, 32'h0);
        chk("post_redir_addr", 64'(addr), 64'h100);
        chk("post_redir_en", 64'(en), 64'd1);
        chk("post_redir_valid", 64'(valid), 64'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("post_redir_v1", 64'(valid), 64'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("post_redir_v2", 64'(valid), 64'd1);
`ifdef KAYRV32_FETCH_PERFCNT_EN
        chk("redir_stall", 64'(stall), 64'd5);
`endif
        repeat (3) cyc(1'b1, 1'b0, 32'h0);

        // fill FIFO, then back-to-back redirects; last one wins
        repeat (2) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0000_0300);
        chk("bb1_en", 64'(en), 64'd0);
        chk("bb1_valid", 64'(valid), 64'd0);
        cyc(1'b1, 1'b1, 32'h0000_0207);
        chk("bb2_en", 64'(en), 64'd0);
        q.delete();
        push_seq(32'h0000_0204, 30);
        cyc(1'b1, 1'b0, 32'h0);
        chk("bb_addr", 64'(addr), 64'h204);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("bb_valid", 64'(valid), 64'd1);
`ifdef KAYRV32_FETCH_PERFCNT_EN
        chk("bb_stall", 64'(stall), 64'd9);
`endif
        repeat (3) cyc(1'b1, 1'b0, 32'h0);

        // async reset between edges
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_en", 64'(en), 64'd0);
        chk("arst_addr", 64'(addr), 64'h0);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_instr", 64'(instr), 64'h0);
        chk("arst_ipc", 64'(ipc), 64'h0);
`ifdef KAYRV32_FETCH_PERFCNT_EN
        chk("arst_stall", 64'(stall), 64'd0);
`endif
        repeat (2) cyc(1'b1, 1'b0, 32'h0);
        q.delete();
        push_seq(32'h0, 20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_en", 64'(en), 64'd1);
        chk("rel_addr", 64'(addr), 64'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("rel_valid", 64'(valid), 64'd1);
        repeat (4) cyc(1'b1, 1'b0, 32'h0);
        chk("rel_next", 64'(q[0][63:32]), 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
